// File: rtl/uvmt_cv32e40x_pkg.sv
// Shared types and helpers for the CV32E40X data-side PMA lookup sequencer.
package uvmt_cv32e40x_pkg;

   localparam logic [3:0] PMA_SEQ_WORD_BYTES = 4'd4;

   // Result of one combinational PMA region lookup.
   typedef struct packed {
      logic allow;
      logic main;
      logic bufferable;
   } pma_status_t;

   typedef enum logic [1:0] {
      PMA_SEQ_IDLE      = 2'd0,
      PMA_SEQ_LOOKUP_LO = 2'd1,
      PMA_SEQ_LOOKUP_HI = 2'd2,
      PMA_SEQ_RESP      = 2'd3
   } pma_seq_state_e;

   // Request as held while the lookups are in progress (size already normalised).
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        load;
      logic        dbg;
      logic        pushpop;
      logic        id;
   } pma_seq_req_t;

   // Number of bytes touched by an access of the given (normalised) size.
   function automatic logic [3:0] pma_seq_bytes(input logic [1:0] size);
      logic [3:0] bytes;
      case (size)
         2'd0:    bytes = 4'd1;
         2'd1:    bytes = 4'd2;
         default: bytes = 4'd4;
      endcase
      return bytes;
   endfunction

   // Address is not a multiple of the access size.
   function automatic logic pma_seq_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
      return (({2'b00, addr_lo} & (pma_seq_bytes(size) - 4'd1)) != 4'd0);
   endfunction

   // Access spills over into the next word.
   function automatic logic pma_seq_split(input logic [1:0] addr_lo, input logic [1:0] size);
      return (({2'b00, addr_lo} + pma_seq_bytes(size)) > PMA_SEQ_WORD_BYTES);
   endfunction

endpackage

// File: rtl/uvmt_cv32e40x_rr_arbiter2.sv
// Two-port round-robin arbiter; the last-grant pointer only moves when a grant is accepted.
module uvmt_cv32e40x_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic last_r;

   // Grant a lone requester; on contention favour the port not granted last.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_r ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Remember which port won the most recent accepted grant (reset favours port 0 next).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_r <= 1'b1;
      end else if (accept) begin
         last_r <= gnt[1];
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/uvmt_cv32e40x_pma_lookup_sequencer.sv
// Shares one data-side PMA lookup port between two requesters, splitting word-crossing
// accesses into two lookups and returning one merged, tagged response per request.
// Optional feature: define UVMT_CV32E40X_PMA_SEQ_STATS_EN to add saturating statistics counters.
module uvmt_cv32e40x_pma_lookup_sequencer
   import uvmt_cv32e40x_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ-1:0][31:0]   req_addr_i,
   input  logic [NUM_REQ-1:0][1:0]    req_size_i,
   input  logic [NUM_REQ-1:0]         req_load_i,
   input  logic [NUM_REQ-1:0]         req_dbg_i,
   input  logic [NUM_REQ-1:0]         req_pushpop_i,
   output logic [31:0]                pma_addr_o,
   output logic                       pma_misaligned_o,
   output logic                       pma_load_o,
   output logic                       pma_dbg_o,
   output logic                       pma_pushpop_o,
   input  pma_status_t                pma_status_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic                       rsp_id_o,
   output logic                       rsp_allow_o,
   output logic                       rsp_main_o,
   output logic                       rsp_bufferable_o,
   output logic                       rsp_split_o,
   output logic [31:0]                rsp_fault_addr_o
`ifdef UVMT_CV32E40X_PMA_SEQ_STATS_EN
  ,output logic [31:0]                stat_split_cnt_o,
   output logic [31:0]                stat_deny_cnt_o,
   output logic [31:0]                stat_illegal_cnt_o
`endif
);

   if (NUM_REQ != 2) begin : g_num_req_check
      $error("uvmt_cv32e40x_pma_lookup_sequencer supports exactly two requesters");
   end

   pma_seq_state_e state_r;
   pma_seq_state_e state_nxt_s;
   pma_seq_req_t   req_r;
   logic           illegal_r;
   logic           allow_r;
   logic           main_r;
   logic           buf_r;
   logic           lo_deny_r;
   logic [31:0]    fault_r;
   logic [1:0]     gnt_s;
   logic           accept_s;
   logic           sel_s;
   logic           split_s;
   logic           mis_s;
   logic [31:0]    hi_addr_s;

   assign sel_s     = gnt_s[1];
   assign accept_s  = (state_r == PMA_SEQ_IDLE) && ((req_valid_i & gnt_s) != 2'b00);
   assign split_s   = pma_seq_split(req_r.addr[1:0], req_r.size);
   assign mis_s     = pma_seq_misaligned(req_r.addr[1:0], req_r.size);
   assign hi_addr_s = {req_r.addr[31:2], 2'b00} + 32'd4;

   uvmt_cv32e40x_rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid_i),
      .accept (accept_s),
      .gnt    (gnt_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= PMA_SEQ_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus the request, lookup and response outputs of each state.
   always_comb begin
      state_nxt_s      = state_r;
      req_ready_o      = 2'b00;
      pma_addr_o       = 32'd0;
      pma_misaligned_o = 1'b0;
      pma_load_o       = 1'b0;
      pma_dbg_o        = 1'b0;
      pma_pushpop_o    = 1'b0;
      rsp_valid_o      = 1'b0;
      rsp_id_o         = 1'b0;
      rsp_allow_o      = 1'b0;
      rsp_main_o       = 1'b0;
      rsp_bufferable_o = 1'b0;
      rsp_split_o      = 1'b0;
      rsp_fault_addr_o = 32'd0;
      case (state_r)
         PMA_SEQ_IDLE: begin
            req_ready_o = gnt_s;
            if (accept_s) begin
               state_nxt_s = PMA_SEQ_LOOKUP_LO;
            end else begin
               state_nxt_s = PMA_SEQ_IDLE;
            end
         end
         PMA_SEQ_LOOKUP_LO: begin
            pma_addr_o       = req_r.addr;
            pma_misaligned_o = mis_s;
            pma_load_o       = req_r.load;
            pma_dbg_o        = req_r.dbg;
            pma_pushpop_o    = req_r.pushpop;
            if (split_s) begin
               state_nxt_s = PMA_SEQ_LOOKUP_HI;
            end else begin
               state_nxt_s = PMA_SEQ_RESP;
            end
         end
         PMA_SEQ_LOOKUP_HI: begin
            pma_addr_o       = hi_addr_s;
            pma_misaligned_o = mis_s;
            pma_load_o       = req_r.load;
            pma_dbg_o        = req_r.dbg;
            pma_pushpop_o    = req_r.pushpop;
            state_nxt_s      = PMA_SEQ_RESP;
         end
         PMA_SEQ_RESP: begin
            rsp_valid_o      = 1'b1;
            rsp_id_o         = req_r.id;
            rsp_allow_o      = allow_r;
            rsp_main_o       = main_r;
            rsp_bufferable_o = buf_r;
            rsp_split_o      = split_s;
            rsp_fault_addr_o = fault_r;
            if (rsp_ready_i) begin
               state_nxt_s = PMA_SEQ_IDLE;
            end else begin
               state_nxt_s = PMA_SEQ_RESP;
            end
         end
         default: begin
            state_nxt_s = PMA_SEQ_IDLE;
         end
      endcase
   end

   // Latch the granted request and fold each lookup result into the merged response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_r     <= '0;
         illegal_r <= 1'b0;
         allow_r   <= 1'b0;
         main_r    <= 1'b0;
         buf_r     <= 1'b0;
         lo_deny_r <= 1'b0;
         fault_r   <= 32'd0;
      end else begin
         case (state_r)
            PMA_SEQ_IDLE: begin
               if (accept_s) begin
                  req_r.addr    <= req_addr_i[sel_s];
                  req_r.size    <= (req_size_i[sel_s] == 2'd3) ? 2'd2 : req_size_i[sel_s];
                  req_r.load    <= req_load_i[sel_s];
                  req_r.dbg     <= req_dbg_i[sel_s];
                  req_r.pushpop <= req_pushpop_i[sel_s];
                  req_r.id      <= sel_s;
                  illegal_r     <= (req_size_i[sel_s] == 2'd3);
               end else begin
                  req_r     <= req_r;
                  illegal_r <= illegal_r;
               end
            end
            PMA_SEQ_LOOKUP_LO: begin
               allow_r   <= pma_status_i.allow;
               main_r    <= pma_status_i.main;
               buf_r     <= pma_status_i.bufferable;
               lo_deny_r <= !pma_status_i.allow;
               fault_r   <= pma_status_i.allow ? 32'd0 : req_r.addr;
            end
            PMA_SEQ_LOOKUP_HI: begin
               allow_r <= allow_r & pma_status_i.allow;
               main_r  <= main_r & pma_status_i.main;
               buf_r   <= buf_r & pma_status_i.bufferable;
               // The low address keeps priority when both halves deny.
               if (!lo_deny_r && !pma_status_i.allow) begin
                  fault_r <= hi_addr_s;
               end else begin
                  fault_r <= fault_r;
               end
            end
            default: begin
               req_r <= req_r;
            end
         endcase
      end
   end

`ifdef UVMT_CV32E40X_PMA_SEQ_STATS_EN
   logic [31:0] stat_split_r;
   logic [31:0] stat_deny_r;
   logic [31:0] stat_illegal_r;
   logic        rsp_hs_s;

   assign rsp_hs_s           = (state_r == PMA_SEQ_RESP) && rsp_ready_i;
   assign stat_split_cnt_o   = stat_split_r;
   assign stat_deny_cnt_o    = stat_deny_r;
   assign stat_illegal_cnt_o = stat_illegal_r;

   // Saturating event counters, bumped once per completed response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_split_r   <= 32'd0;
         stat_deny_r    <= 32'd0;
         stat_illegal_r <= 32'd0;
      end else begin
         if (rsp_hs_s && split_s && (stat_split_r != 32'hFFFF_FFFF)) begin
            stat_split_r <= stat_split_r + 32'd1;
         end else begin
            stat_split_r <= stat_split_r;
         end
         if (rsp_hs_s && !allow_r && (stat_deny_r != 32'hFFFF_FFFF)) begin
            stat_deny_r <= stat_deny_r + 32'd1;
         end else begin
            stat_deny_r <= stat_deny_r;
         end
         if (rsp_hs_s && illegal_r && (stat_illegal_r != 32'hFFFF_FFFF)) begin
            stat_illegal_r <= stat_illegal_r + 32'd1;
         end else begin
            stat_illegal_r <= stat_illegal_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_lookup_sequencer.sv
// Scoreboard bench for the PMA lookup sequencer: directed requests push expected
// responses, a monitor pops and compares each response handshake.
module tb_uvmt_cv32e40x_pma_lookup_sequencer;
   import uvmt_cv32e40x_pkg::*;

   typedef struct {
      logic        id;
      logic        allow;
      logic        main;
      logic        bufb;
      logic        split;
      logic [31:0] fault;
      int          lat;
      int          nlook;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        mis;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_addr;
   logic [1:0][1:0]  req_size;
   logic [1:0]       req_load;
   logic [1:0]       req_dbg;
   logic [1:0]       req_pushpop;
   logic [31:0]      pma_addr;
   logic             pma_mis;
   logic             pma_load;
   logic             pma_dbg;
   logic             pma_pushpop;
   pma_status_t      pma_status;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic             rsp_allow;
   logic             rsp_main;
   logic             rsp_buf;
   logic             rsp_split;
   logic [31:0]      rsp_fault;
`ifdef UVMT_CV32E40X_PMA_SEQ_STATS_EN
   logic [31:0]      stat_split;
   logic [31:0]      stat_deny;
   logic [31:0]      stat_illegal;
`endif

   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;
   exp_t        exp_q[$];
   int          acc_q[$];
   logic [31:0] look_addr_q[$];
   logic        look_mis_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Zero-latency PMA model: two denied words, main unless bit 28, bufferable from bit 12.
   always_comb begin
      pma_status.allow      = !((pma_addr == 32'h0000_2004) || (pma_addr == 32'h0000_3000));
      pma_status.main       = !pma_addr[28];
      pma_status.bufferable = pma_addr[12];
   end

   uvmt_cv32e40x_pma_lookup_sequencer #(.NUM_REQ(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_addr_i       (req_addr),
      .req_size_i       (req_size),
      .req_load_i       (req_load),
      .req_dbg_i        (req_dbg),
      .req_pushpop_i    (req_pushpop),
      .pma_addr_o       (pma_addr),
      .pma_misaligned_o (pma_mis),
      .pma_load_o       (pma_load),
      .pma_dbg_o        (pma_dbg),
      .pma_pushpop_o    (pma_pushpop),
      .pma_status_i     (pma_status),
      .rsp_valid_o      (rsp_valid),
      .rsp_ready_i      (rsp_ready),
      .rsp_id_o         (rsp_id),
      .rsp_allow_o      (rsp_allow),
      .rsp_main_o       (rsp_main),
      .rsp_bufferable_o (rsp_buf),
      .rsp_split_o      (rsp_split),
      .rsp_fault_addr_o (rsp_fault)
`ifdef UVMT_CV32E40X_PMA_SEQ_STATS_EN
     ,.stat_split_cnt_o   (stat_split),
      .stat_deny_cnt_o    (stat_deny),
      .stat_illegal_cnt_o (stat_illegal)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_rsp(input logic id, input logic allow, input logic main, input logic bufb,
                             input logic split, input logic [31:0] fault, input int lat,
                             input int nlook, input logic [31:0] lo, input logic [31:0] hi,
                             input logic mis);
      exp_t e;
      e.id = id; e.allow = allow; e.main = main; e.bufb = bufb; e.split = split;
      e.fault = fault; e.lat = lat; e.nlook = nlook; e.lo = lo; e.hi = hi; e.mis = mis;
      exp_q.push_back(e);
   endtask

   // Present a request on port p and return at the falling edge after it is accepted.
   task automatic issue(input int p, input logic [31:0] addr, input logic [1:0] size,
                        input logic ld, input logic dbg, input logic pp);
      int n;
      req_valid[p] = 1'b1; req_addr[p] = addr; req_size[p] = size;
      req_load[p] = ld; req_dbg[p] = dbg; req_pushpop[p] = pp;
      #1;
      n = 0;
      while (!req_ready[p] && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (!req_ready[p]) begin
         tests++; failed++;
         $display("FAIL accept_timeout: port %0d not accepted, got ready=%b expected ready=1", p, req_ready[p]);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic idle_port(input int p);
      req_valid[p] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_outstanding", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic clear_logs();
      acc_q.delete();
      look_addr_q.delete();
      look_mis_q.delete();
   endtask

   // Record accepts and lookups; on every response handshake pop and compare.
   task automatic monitor();
      exp_t        e;
      int          a;
      int          first_cyc = 0;
      bit          in_rsp = 1'b0;
      logic [36:0] snap = '0;
      logic [36:0] cur;
      forever begin
         @(negedge clk); #2;
         if (rst_n !== 1'b1) begin
            in_rsp = 1'b0;
         end else begin
            if ((req_valid & req_ready) != 2'b00) acc_q.push_back(cyc);
            if (pma_addr != 32'd0 || pma_mis) begin
               look_addr_q.push_back(pma_addr);
               look_mis_q.push_back(pma_mis);
            end
            if (rsp_valid) begin
               cur = {rsp_id, rsp_allow, rsp_main, rsp_buf, rsp_split, rsp_fault};
               if (!in_rsp) begin
                  in_rsp = 1'b1; first_cyc = cyc; snap = cur;
               end else begin
                  check("payload_stable", 64'(cur), 64'(snap));
               end
               if (rsp_ready) begin
                  if (exp_q.size() == 0) begin
                     tests++; failed++;
                     $display("FAIL unexpected_rsp: got response id=%0d, expected none", rsp_id);
                  end else begin
                     e = exp_q.pop_front();
                     check("rsp_id", 64'(rsp_id), 64'(e.id));
                     check("rsp_allow", 64'(rsp_allow), 64'(e.allow));
                     check("rsp_main", 64'(rsp_main), 64'(e.main));
                     check("rsp_bufferable", 64'(rsp_buf), 64'(e.bufb));
                     check("rsp_split", 64'(rsp_split), 64'(e.split));
                     check("rsp_fault_addr", 64'(rsp_fault), 64'(e.fault));
                     a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                     check("latency", 64'(first_cyc - a), 64'(e.lat));
                     check("n_lookups", 64'(look_addr_q.size()), 64'(e.nlook));
                     if (look_addr_q.size() > 0) begin
                        check("lookup_lo_addr", 64'(look_addr_q[0]), 64'(e.lo));
                        check("lookup_lo_mis", 64'(look_mis_q[0]), 64'(e.mis));
                     end
                     if (e.nlook == 2 && look_addr_q.size() > 1) begin
                        check("lookup_hi_addr", 64'(look_addr_q[1]), 64'(e.hi));
                        check("lookup_hi_mis", 64'(look_mis_q[1]), 64'(e.mis));
                     end
                  end
                  look_addr_q.delete();
                  look_mis_q.delete();
                  in_rsp = 1'b0;
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; rsp_ready = 1'b1;
      req_valid = '0; req_addr = '0; req_size = '0;
      req_load = '0; req_dbg = '0; req_pushpop = '0;
      fork
         monitor();
      join_none

      // Reset values.
      repeat (3) @(negedge clk);
      #1;
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_pma_addr", 64'(pma_addr), 64'd0);
      check("reset_pma_attrs", 64'({pma_mis, pma_load, pma_dbg, pma_pushpop}), 64'd0);
      check("reset_rsp_payload", 64'({rsp_id, rsp_allow, rsp_main, rsp_buf, rsp_split, rsp_fault}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Aligned word from port 0.
      expect_rsp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2, 1, 32'h1000, 32'h0, 1'b0);
      issue(0, 32'h0000_1000, 2'd2, 1'b1, 1'b0, 1'b0);
      check("lo_lookup_attrs", 64'({pma_load, pma_dbg, pma_pushpop}), 64'(3'b100));
      idle_port(0);
      drain();

      // Split halfword from port 1, high word denied.
      expect_rsp(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2004, 3, 2, 32'h2003, 32'h2004, 1'b1);
      issue(1, 32'h0000_2003, 2'd1, 1'b0, 1'b1, 1'b1);
      check("split_lookup_attrs", 64'({pma_load, pma_dbg, pma_pushpop}), 64'(3'b011));
      idle_port(1);
      drain();

      // Both ports continuously valid: grants alternate starting with port 0.
      expect_rsp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    2, 1, 32'h0000_1100, 32'h0,    1'b0);
      expect_rsp(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3000, 2, 1, 32'h0000_3000, 32'h0,    1'b0);
      expect_rsp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    2, 1, 32'h1000_0004, 32'h0,    1'b0);
      expect_rsp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    2, 1, 32'h0000_0001, 32'h0,    1'b0);
      expect_rsp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    2, 1, 32'h0000_0102, 32'h0,    1'b0);
      expect_rsp(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,    3, 2, 32'h0000_1FFE, 32'h2000, 1'b1);
      fork
         begin
            issue(0, 32'h0000_1100, 2'd0, 1'b1, 1'b0, 1'b0);
            issue(0, 32'h1000_0004, 2'd2, 1'b0, 1'b0, 1'b0);
            issue(0, 32'h0000_0102, 2'd1, 1'b1, 1'b0, 1'b0);
            idle_port(0);
         end
         begin
            issue(1, 32'h0000_3000, 2'd2, 1'b0, 1'b1, 1'b0);
            issue(1, 32'h0000_0001, 2'd0, 1'b1, 1'b1, 1'b0);
            issue(1, 32'h0000_1FFE, 2'd3, 1'b0, 1'b1, 1'b1);
            idle_port(1);
         end
      join
      drain();

      // Top-of-memory word: high lookup wraps to address 0.
      expect_rsp(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 3, 2, 32'hFFFF_FFFF, 32'h0, 1'b1);
      issue(0, 32'hFFFF_FFFF, 2'd2, 1'b1, 1'b0, 1'b0);
      idle_port(0);
      drain();

      // Response back-pressure: payload held, no new request accepted.
      rsp_ready = 1'b0;
      expect_rsp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2, 1, 32'h1000, 32'h0, 1'b0);
      expect_rsp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2, 1, 32'h0010, 32'h0, 1'b0);
      issue(0, 32'h0000_1000, 2'd2, 1'b1, 1'b0, 1'b0);
      idle_port(0);
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk); #1;
         n++;
      end
      req_valid[1] = 1'b1; req_addr[1] = 32'h0000_0010; req_size[1] = 2'd2;
      req_load[1] = 1'b0; req_dbg[1] = 1'b0; req_pushpop[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("stall_req_ready", 64'(req_ready), 64'd0);
         check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      end
      rsp_ready = 1'b1;
      issue(1, 32'h0000_0010, 2'd2, 1'b0, 1'b0, 1'b0);
      idle_port(1);
      drain();

      // Reset during the high lookup drops the request; last-grant returns to its reset value.
      issue(0, 32'h0000_2003, 2'd1, 1'b1, 1'b0, 1'b0);
      idle_port(0);
      @(negedge clk);
      check("abort_hi_addr", 64'(pma_addr), 64'h2004);
      rst_n = 1'b0;
      @(negedge clk); #1;
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort_pma_addr", 64'(pma_addr), 64'd0);
      clear_logs();
      rst_n = 1'b1;
      expect_rsp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2, 1, 32'h0040, 32'h0, 1'b0);
      expect_rsp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2, 1, 32'h0044, 32'h0, 1'b0);
      fork
         begin
            issue(0, 32'h0000_0040, 2'd2, 1'b1, 1'b0, 1'b0);
            idle_port(0);
         end
         begin
            issue(1, 32'h0000_0044, 2'd2, 1'b1, 1'b0, 1'b0);
            idle_port(1);
         end
      join
      drain();

`ifdef UVMT_CV32E40X_PMA_SEQ_STATS_EN
      // Statistics: three splits, two denied, one illegal size.
      rst_n = 1'b0;
      @(negedge clk); #1;
      check("stat_reset", 64'({stat_split, stat_deny}), 64'd0);
      clear_logs();
      rst_n = 1'b1;
      expect_rsp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2004, 3, 2, 32'h2003, 32'h2004, 1'b1);
      issue(0, 32'h0000_2003, 2'd1, 1'b1, 1'b0, 1'b0);
      expect_rsp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 3, 2, 32'h2FFE, 32'h3000, 1'b1);
      issue(0, 32'h0000_2FFE, 2'd3, 1'b1, 1'b0, 1'b0);
      expect_rsp(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 3, 2, 32'h0103, 32'h0104, 1'b1);
      issue(0, 32'h0000_0103, 2'd1, 1'b1, 1'b0, 1'b0);
      idle_port(0);
      drain();
      check("stat_split", 64'(stat_split), 64'd3);
      check("stat_deny", 64'(stat_deny), 64'd2);
      check("stat_illegal", 64'(stat_illegal), 64'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
